// File: rtl/ser_par_pkg.sv
// ----------------------------------------------------------------------------
// ser_par_pkg
// Shared definitions for the parallel-to-serial and serial-to-parallel shift
// register blocks.
//   p2s_state_t : transmitter state (IDLE / SHIFT)
//   cnt_w()     : width of a bit counter able to index every bit of a word
// ----------------------------------------------------------------------------
package ser_par_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } p2s_state_t;

    // Bit counter width for a word of the given size.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/par_2_ser_shift_reg.sv
// ----------------------------------------------------------------------------
// par_2_ser_shift_reg
// Parallel-to-serial transmitter. Words are accepted over a valid/ready
// handshake into a one-entry holding buffer, then shifted out one bit per
// clock. The buffer lets the next word be loaded on the edge after the
// current word's last bit, so streams run with no idle cycle.
//
// Ports
//   clk        : rising-edge clock
//   resetn     : synchronous active-low reset
//   din        : parallel word to transmit
//   din_valid  : din holds a valid word
//   din_ready  : block can accept a word this cycle
//   dout       : serial data bit
//   dout_valid : dout carries a word bit this cycle
//   dout_last  : dout is the final bit of its word
// ----------------------------------------------------------------------------
module par_2_ser_shift_reg
    import ser_par_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_last
);

    localparam int            CW       = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    p2s_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;

    logic                  accept;
    logic                  load;

    assign accept = din_valid && din_ready;

    // Next-state logic. A buffer-to-shifter load is resolved first so that an
    // accept on the same edge refills the buffer and leaves it marked full.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Shift toward whichever end feeds dout.
                sreg_d = MSB_FIRST ? {sreg_q[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, sreg_q[DATA_WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Clearing here keeps the counter from ever wrapping.
                    cnt_d = '0;
                    if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sreg_d       = hold_data_q;
            cnt_d        = '0;
            hold_valid_d = 1'b0;
        end

        if (accept) begin
            hold_data_d  = din;
            hold_valid_d = 1'b1;
        end
    end

    // State registers; reset drops any partial or buffered word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Outputs depend only on registers, so they are glitch-free per cycle.
    assign din_ready  = !hold_valid_q;
    assign dout_valid = (state_q == SHIFT);
    assign dout       = dout_valid && (MSB_FIRST ? sreg_q[DATA_WIDTH-1] : sreg_q[0]);
    assign dout_last  = dout_valid && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_par_2_ser_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_par_2_ser_shift_reg
// Directed bench for par_2_ser_shift_reg. Two instances share the stimulus:
// one MSB-first, one LSB-first. Each cycle the 4-bit status
// {din_ready, dout_valid, dout_last, dout} is compared with a hand-built
// table of expected values.
// ----------------------------------------------------------------------------
module tb_par_2_ser_shift_reg;

    logic       clk;
    logic       resetn;
    logic [3:0] din;
    logic       din_valid;

    logic       msbReady, msbDout, msbValid, msbLast;
    logic       lsbReady, lsbDout, lsbValid, lsbLast;

    logic [3:0] msbStatus;
    logic [3:0] lsbStatus;

    int         checksTotal;
    int         checksPassed;
    int         hsCount;

    logic [4:0] wordQ[$];
    logic [3:0] expTbl[0:15];
    logic [3:0] expLsbTbl[0:15];

    par_2_ser_shift_reg #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (msbReady),
        .dout      (msbDout),
        .dout_valid(msbValid),
        .dout_last (msbLast)
    );

    par_2_ser_shift_reg #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (lsbReady),
        .dout      (lsbDout),
        .dout_valid(lsbValid),
        .dout_last (lsbLast)
    );

    assign msbStatus = {msbReady, msbValid, msbLast, msbDout};
    assign lsbStatus = {lsbReady, lsbValid, lsbLast, lsbDout};

    // Free-running clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and stop on the following falling edge, where
    // outputs are sampled and new inputs are driven.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset;
        resetn    = 1'b0;
        din_valid = 1'b0;
        tick();
        tick();
        resetn  = 1'b1;
        hsCount = 0;
        wordQ.delete();
    endtask

    // Unpack a nibble string (first nibble = first cycle) into a table.
    task automatic loadTbl(input logic [63:0] v, input int n, input bit lsbSel);
        for (int i = 0; i < n; i++) begin
            if (lsbSel) expLsbTbl[i] = v[4*(n-1-i) +: 4];
            else        expTbl[i]    = v[4*(n-1-i) +: 4];
        end
    endtask

    // Queue items: bit4=1 is a forced idle cycle, otherwise bits[3:0] is a
    // word presented with din_valid held until it is accepted.
    task automatic applyStimulus(input string tag, input int n, input bit chkLsb);
        for (int c = 0; c < n; c++) begin
            if (wordQ.size() > 0) begin
                if (wordQ[0][4]) begin
                    din_valid = 1'b0;
                    void'(wordQ.pop_front());
                end else begin
                    din_valid = 1'b1;
                    din       = wordQ[0][3:0];
                    if (msbReady) begin
                        hsCount++;
                        void'(wordQ.pop_front());
                    end
                end
            end else begin
                din_valid = 1'b0;
            end
            tick();
            checkOutput($sformatf("%s[%0d]", tag, c), {4'b0, msbStatus}, {4'b0, expTbl[c]});
            if (chkLsb)
                checkOutput($sformatf("%s_lsb[%0d]", tag, c), {4'b0, lsbStatus}, {4'b0, expLsbTbl[c]});
        end
        din_valid = 1'b0;
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        hsCount      = 0;
        resetn       = 1'b0;
        din          = 4'h0;
        din_valid    = 1'b0;
        @(negedge clk);

        // Reset state
        doReset();
        checkOutput("rst_msb", {4'b0, msbStatus}, 8'h08);
        checkOutput("rst_lsb", {4'b0, lsbStatus}, 8'h08);

        // Single word 1011: bits 1,0,1,1 after edges 2..5, last on the 4th
        doReset();
        wordQ.push_back(5'h0B);
        loadTbl(64'h0DCDF8, 6, 1'b0);
        applyStimulus("single", 6, 1'b0);
        checkOutput("single_hs", hsCount[7:0], 8'd1);

        // Back-to-back 1011, 0110: eight contiguous valid bits
        doReset();
        wordQ.push_back(5'h0B);
        wordQ.push_back(5'h06);
        loadTbl(64'h0D457CDDE8, 10, 1'b0);
        applyStimulus("b2b", 10, 1'b0);
        checkOutput("b2b_hs", hsCount[7:0], 8'd2);

        // Handshake on a reset edge is discarded
        doReset();
        resetn    = 1'b0;
        din_valid = 1'b1;
        din       = 4'hF;
        tick();
        resetn    = 1'b1;
        din_valid = 1'b0;
        checkOutput("rsths0", {4'b0, msbStatus}, 8'h08);
        tick();
        checkOutput("rsths1", {4'b0, msbStatus}, 8'h08);
        tick();
        checkOutput("rsths2", {4'b0, msbStatus}, 8'h08);

        // Reset after two bits of 1111: no residual bits afterwards
        doReset();
        wordQ.push_back(5'h0F);
        loadTbl(64'h0DD, 3, 1'b0);
        applyStimulus("mid", 3, 1'b0);
        resetn = 1'b0;
        tick();
        checkOutput("mid_rst", {4'b0, msbStatus}, 8'h08);
        resetn = 1'b1;
        loadTbl(64'h888, 3, 1'b0);
        applyStimulus("mid_post", 3, 1'b0);

        // Word 0001: MSB-first gives 0,0,0,1; LSB-first gives 1,0,0,0
        doReset();
        wordQ.push_back(5'h01);
        loadTbl(64'h0CCCF8, 6, 1'b0);
        loadTbl(64'h0DCCE8, 6, 1'b1);
        applyStimulus("order", 6, 1'b1);

        // Three words with valid held: ready pulses on each load edge
        doReset();
        wordQ.push_back(5'h0B);
        wordQ.push_back(5'h06);
        wordQ.push_back(5'h0C);
        loadTbl(64'h0D457C556DDCE8, 14, 1'b0);
        applyStimulus("stall", 14, 1'b0);
        checkOutput("stall_hs", hsCount[7:0], 8'd3);

        // Three-cycle gap absorbed by buffer slack: no bubble
        doReset();
        wordQ.push_back(5'h0B);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h06);
        loadTbl(64'h0DCD7CDDE8, 10, 1'b0);
        applyStimulus("gap3", 10, 1'b0);
        checkOutput("gap3_hs", hsCount[7:0], 8'd2);

        // Four-cycle gap: one idle cycle between the words
        doReset();
        wordQ.push_back(5'h0B);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h10);
        wordQ.push_back(5'h06);
        loadTbl(64'h0DCDF0CDDE8, 11, 1'b0);
        applyStimulus("gap4", 11, 1'b0);
        checkOutput("gap4_hs", hsCount[7:0], 8'd2);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/par_2_ser_shift_reg.md
# par_2_ser_shift_reg

Parallel-to-serial transmitter that sits directly upstream of `ser_2_par_shift_reg`. It accepts `DATA_WIDTH`-bit words over a valid/ready handshake and shifts them out one bit per clock on a serial line. The order is chosen so a downstream serial-to-parallel shift register reconstructs each word unchanged. A one-entry holding buffer lets consecutive words stream with no idle cycle between them.

## Interface
- `DATA_WIDTH`, 4: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 transmits bit `DATA_WIDTH-1` first; 0 transmits bit 0 first.

- `clk`, in, 1: single clock; all logic acts on the rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `din`, in, `DATA_WIDTH`: parallel word to transmit.
- `din_valid`, in, 1: `din` holds a valid word.
- `din_ready`, out, 1: block can accept a word this cycle.
- `dout`, out, 1: serial data bit.
- `dout_valid`, out, 1: `dout` carries a word bit this cycle.
- `dout_last`, out, 1: the current `dout` bit is the final bit of its word.

## Operation
- **Handshake.** A word is accepted on a rising edge where `din_valid && din_ready`.
  - `din_ready = !hold_valid`, driven combinationally from a register.
  - `din` is don't-care when `din_valid` is 0.
- **Holding buffer.** Signals `hold_data` and `hold_valid`. An accepted word is written here and `hold_valid` sets.
- **Shifter.** Signals `sreg[DATA_WIDTH-1:0]` and bit counter `cnt` of width `$clog2(DATA_WIDTH)`.
- **State machine.**
  - IDLE: `dout_valid`=0 and `dout`=0. If `hold_valid`=1: load `sreg` from `hold_data`, clear `hold_valid`, set `cnt`=0, and go to SHIFT.
  - SHIFT:
    - `dout` = `sreg[DATA_WIDTH-1]` when `MSB_FIRST`=1, otherwise `sreg[0]`.
    - `dout_valid`=1 and `dout_last = (cnt == DATA_WIDTH-1)`.
    - Each edge: shift `sreg` toward the output end and increment `cnt`.
    - On the edge where `cnt == DATA_WIDTH-1`: if `hold_valid`=1, reload from the buffer, clear `hold_valid`, set `cnt`=0, and stay in SHIFT. Otherwise go to IDLE.
- **Simultaneous accept and load.** When an accept and a buffer-to-shifter load happen on the same edge, the buffer takes the new word and `hold_valid` stays 1.
- **Data path.** Purely bit movement; no arithmetic. `cnt` never wraps past `DATA_WIDTH-1`.

## Timing
- **Reset values** while `resetn`=0 at an edge:
  - State IDLE, `sreg`=0, `cnt`=0, `hold_valid`=0.
  - Outputs: `dout`=0, `dout_valid`=0, `dout_last`=0, `din_ready`=1.
- **Handshake during reset.** A handshake on a reset edge is discarded; reset wins.
- **Reset mid-word.** The partial word and any buffered word are dropped. Outputs take reset values in the cycle after the reset edge. No residual bits appear after reset is released.
- **Latency.** Word accepted at edge k while IDLE → first bit appears on `dout` after edge k+1. The last bit appears after edge k+`DATA_WIDTH`.
- **Throughput.** One word per `DATA_WIDTH` cycles.
  - With the upstream always valid, `dout_valid` stays high continuously.
  - `din_ready` is high for 1 cycle per word in steady state.
- **Back-to-back words.** No bubble between words when the next word is accepted no later than the edge at which the current word's last bit is shifted out.
- **Upstream stall.** When upstream stalls, SHIFT → IDLE after the last bit and `dout_valid` falls the following cycle.
- **Downstream pairing.** The downstream register samples `dout` on the same edges that advance `sreg`. Exactly `DATA_WIDTH` valid bits are produced per word.

## Structure
- Shared package `ser_par_pkg`:
  - `typedef enum logic {IDLE, SHIFT} p2s_state_t`.
  - Function `cnt_w(width)` returning `$clog2(width)`; both shift-register blocks use it.
- Single module; no sub-module is warranted. The holding buffer and shifter are small enough to stay inline.

## Test plan
- **Single word.** Reset 2 cycles; accept `din`=4'b1011 → `dout` = 1,0,1,1 on 4 consecutive cycles with `dout_valid`=1. `dout_last`=1 only on the 4th bit; `dout_valid` returns to 0 the next cycle.
- **Back-to-back.** Hold `din_valid`=1 with 4'b1011 then 4'b0110 → 8 consecutive valid bits 1,0,1,1,0,1,1,0. `dout_last` pulses on bits 4 and 8. Exactly two handshakes occur.
- **Reset mid-word.** Accept 4'b1111; assert `resetn`=0 after 2 bits → `dout`, `dout_valid` and `dout_last` are 0 the next cycle and `din_ready`=1. After release, no further bits appear until a new handshake.
- **LSB-first.** `MSB_FIRST`=0 with word 4'b0001 → `dout` = 1,0,0,0.
- **Stall / backpressure.** Accept 3 words with `din_valid` held high:
  - `din_ready` deasserts while the buffer is full and re-asserts on each load edge.
  - Deasserting `din_valid` for 3 cycles mid-stream → `dout_valid` drops for exactly the gap length minus any buffered slack.
- **Loopback.** Connect to `ser_2_par_shift_reg` (`DATA_WIDTH`=4), send 4'b1011 → that block's `dout` equals 4'b1011 on the cycle after this block's `dout_last`.
